rv_dec_mt: RTL and testbench
============================

RV_DEC_MT -- requirements
Module: rv_dec_mt

Interface
REQ-001 Parameter NTHREADS, default 4, number of hardware threads sharing the decoder (1..16).
REQ-002 Parameter TID_W, default clog2(NTHREADS) (minimum 1), thread-id width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 in_valid  in  1  fetch offers an instruction.
REQ-006 in_ready  out  1  decoder accepts the offered instruction this cycle.
REQ-007 in_inst  in  32  raw RV32I instruction word.
REQ-008 in_pc  in  32  PC of in_inst.
REQ-009 in_tid  in  TID_W  issuing thread.
REQ-010 out_valid  out  1  decoded entry available.
REQ-011 out_ready  in  1  execute stage consumes the entry.
REQ-012 out_inst / out_pc / out_tid  out  32/32/TID_W  passthrough of the accepted entry.
REQ-013 out_ctrl  out  dec_ctrl_t  opcode, rs1, rs2, rd, funct3, funct7, rs1_en, rs2_en, rd_wr, f3_en, f7_en, mem_en, mem_wr, csr_en, csr_wr, pc_load.
REQ-014 out_imm  out  32  sign-extended immediate.
REQ-015 out_illegal  out  1  entry is an illegal instruction.
REQ-016 redirect_valid / redirect_tid  in  1/TID_W  execute has resolved a control transfer for that thread.
REQ-017 flush_valid / flush_tid  in  1/TID_W  kill all in-flight entries of that thread.

Function
REQ-018 Transfer on in_valid&in_ready; on out_valid&out_ready; latency accept->out_valid exactly 1 cycle.
REQ-019 Storage: main register plus one skid register; out_* always driven from main; order across all threads preserved.
REQ-020 in_ready = !skid_full && !pend[in_tid]; no combinational path from out_ready to in_ready.
REQ-021 Accept while main empty or draining -> main; accept while main held (out_valid & !out_ready) -> skid; skid moves to main the cycle main drains.
REQ-022 Field extraction: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25].
REQ-023 Enables: LOAD rs1_en,rd_wr,f3_en,mem_en; STORE rs1_en,rs2_en,f3_en,mem_en,mem_wr; OP-IMM rs1_en,rd_wr,f3_en (f7_en only for funct3 001/101); OP rs1_en,rs2_en,rd_wr,f3_en,f7_en; BRANCH rs1_en,rs2_en,f3_en,pc_load; JAL rd_wr,pc_load; JALR rs1_en,rd_wr,pc_load; LUI/AUIPC rd_wr; MISC-MEM f3_en only.
REQ-024 SYSTEM funct3!=000: csr_en=1, rd_wr=1, rs1_en=!funct3[2], csr_wr=0 when funct3[1]=1 and rs1 field=0, else 1; funct3==000 (ecall/ebreak/mret): pc_load=1, all other enables 0.
REQ-025 Immediate per RV32I I/S/B/U/J formats, bit 31 sign-extended; R-type and SYSTEM funct3==000 give 0.
REQ-026 Illegal: inst[1:0]!=11, unlisted opcode, OP funct7 not in {0000000,0100000}, or SUB/SRA-style funct7 on a funct3 that disallows it; illegal entries carry out_illegal=1 and all enables 0.
REQ-027 pend[t] set when an entry of thread t with pc_load=1 or out_illegal=1 is accepted; cleared by redirect_valid with redirect_tid=t or by flush of t.
REQ-028 Set and clear of the same pend bit in one cycle: set wins.
REQ-029 flush_valid: main/skid entries with tid=flush_tid invalidated that cycle (skid compacts into main if main killed); a same-cycle input of that tid is consumed and discarded; other threads unaffected.
REQ-030 NTHREADS=1: in_tid/out_tid ignored/zero, single pend bit.

Reset
REQ-031 rst_n=0 at a clock edge: main and skid invalid, pend all 0, out_valid=0, out_illegal=0, out_ctrl/out_imm/out_inst/out_pc/out_tid 0; in_ready=1 in the first cycle after release.
REQ-032 Reset mid-transfer drops all held entries without emitting them.

Structure
REQ-033 Shared package rv_pkg: opcode localparams, dec_ctrl_t struct, immediate-format enum.
REQ-034 Combinational decode as sub-module rv_dec_core (inst -> dec_ctrl_t, imm, illegal), instantiated once at the input.
REQ-035 Only the wrapper holds state: skid pipeline and pend vector.

Verification
REQ-036 ADD x3,x1,x2 (0x002081B3) tid 0, out_ready=1 -> next cycle out_valid=1, rs1_en=rs2_en=rd_wr=1, rd=3, imm=0.
REQ-037 Hold out_ready=0 over 3 back-to-back accepts -> 2 accepted, in_ready=0 on third; release -> 2 entries in order, none lost/duplicated.
REQ-038 JAL tid 1 accepted -> in_ready=0 whenever in_tid=1, =1 for tid 2; redirect_valid tid 1 -> in_ready for tid 1 returns next cycle.
REQ-039 0xFFFFFFFF and OP with funct7=0000001 -> out_illegal=1, all enables 0, pend set for that tid.
REQ-040 Main=tid 2, skid=tid 3, flush tid 2 -> tid 3 presented next cycle, tid 2 never emitted.
REQ-041 rst_n low one cycle with both registers full -> out_valid=0 next cycle, pend=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, decoded control word and immediate formats.
package rv_pkg;

    localparam logic [6:0] OpcLoad    = 7'b0000011;
    localparam logic [6:0] OpcMiscMem = 7'b0001111;
    localparam logic [6:0] OpcOpImm   = 7'b0010011;
    localparam logic [6:0] OpcAuipc   = 7'b0010111;
    localparam logic [6:0] OpcStore   = 7'b0100011;
    localparam logic [6:0] OpcOp      = 7'b0110011;
    localparam logic [6:0] OpcLui     = 7'b0110111;
    localparam logic [6:0] OpcBranch  = 7'b1100011;
    localparam logic [6:0] OpcJalr    = 7'b1100111;
    localparam logic [6:0] OpcJal     = 7'b1101111;
    localparam logic [6:0] OpcSystem  = 7'b1110011;

    localparam logic [6:0] Funct7Zero = 7'b0000000;
    localparam logic [6:0] Funct7Alt  = 7'b0100000;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       rs1_en;
        logic       rs2_en;
        logic       rd_wr;
        logic       f3_en;
        logic       f7_en;
        logic       mem_en;
        logic       mem_wr;
        logic       csr_en;
        logic       csr_wr;
        logic       pc_load;
    } dec_ctrl_t;

    typedef enum logic [2:0] {
        ImmNone,
        ImmI,
        ImmS,
        ImmB,
        ImmU,
        ImmJ
    } imm_fmt_e;

    function automatic logic [31:0] imm_extract(input logic [31:0] inst, input imm_fmt_e fmt);
        logic [31:0] imm;
        unique case (fmt)
            ImmI:    imm = {{20{inst[31]}}, inst[31:20]};
            ImmS:    imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            ImmB:    imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            ImmU:    imm = {inst[31:12], 12'b0};
            ImmJ:    imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/rv_dec_core.sv
// Purely combinational RV32I decoder: raw word to control word, immediate and illegal flag.
module rv_dec_core
    import rv_pkg::*;
(
    input  logic [31:0] inst,
    output dec_ctrl_t   ctrl,
    output logic [31:0] imm,
    output logic        illegal
);

    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       bad;
    imm_fmt_e   fmt;
    dec_ctrl_t  fields;
    dec_ctrl_t  dec;

    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    always_comb begin
        fields        = '0;
        fields.opcode = inst[6:0];
        fields.rd     = inst[11:7];
        fields.funct3 = funct3;
        fields.rs1    = inst[19:15];
        fields.rs2    = inst[24:20];
        fields.funct7 = funct7;
    end

    always_comb begin
        dec = fields;
        fmt = ImmNone;
        bad = 1'b0;
        case (inst[6:0])
            OpcLoad: begin
                dec.rs1_en = 1'b1;
                dec.rd_wr  = 1'b1;
                dec.f3_en  = 1'b1;
                dec.mem_en = 1'b1;
                fmt        = ImmI;
            end
            OpcStore: begin
                dec.rs1_en = 1'b1;
                dec.rs2_en = 1'b1;
                dec.f3_en  = 1'b1;
                dec.mem_en = 1'b1;
                dec.mem_wr = 1'b1;
                fmt        = ImmS;
            end
            OpcOpImm: begin
                dec.rs1_en = 1'b1;
                dec.rd_wr  = 1'b1;
                dec.f3_en  = 1'b1;
                fmt        = ImmI;
                // Only the shifts carry a funct7; SRAI is the sole alternate encoding.
                if (funct3 == 3'b001) begin
                    dec.f7_en = 1'b1;
                    bad       = (funct7 != Funct7Zero);
                end else if (funct3 == 3'b101) begin
                    dec.f7_en = 1'b1;
                    bad       = (funct7 != Funct7Zero) && (funct7 != Funct7Alt);
                end
            end
            OpcOp: begin
                dec.rs1_en = 1'b1;
                dec.rs2_en = 1'b1;
                dec.rd_wr  = 1'b1;
                dec.f3_en  = 1'b1;
                dec.f7_en  = 1'b1;
                if (funct7 == Funct7Alt) begin
                    bad = (funct3 != 3'b000) && (funct3 != 3'b101);
                end else begin
                    bad = (funct7 != Funct7Zero);
                end
            end
            OpcBranch: begin
                dec.rs1_en  = 1'b1;
                dec.rs2_en  = 1'b1;
                dec.f3_en   = 1'b1;
                dec.pc_load = 1'b1;
                fmt         = ImmB;
            end
            OpcJal: begin
                dec.rd_wr   = 1'b1;
                dec.pc_load = 1'b1;
                fmt         = ImmJ;
            end
            OpcJalr: begin
                dec.rs1_en  = 1'b1;
                dec.rd_wr   = 1'b1;
                dec.pc_load = 1'b1;
                fmt         = ImmI;
            end
            OpcLui, OpcAuipc: begin
                dec.rd_wr = 1'b1;
                fmt       = ImmU;
            end
            OpcMiscMem: begin
                dec.f3_en = 1'b1;
                fmt       = ImmI;
            end
            OpcSystem: begin
                if (funct3 == 3'b000) begin
                    dec.pc_load = 1'b1;
                end else begin
                    dec.csr_en = 1'b1;
                    dec.rd_wr  = 1'b1;
                    dec.rs1_en = !funct3[2];
                    // CSRRS/CSRRC with a zero source only read the CSR.
                    dec.csr_wr = !(funct3[1] && (inst[19:15] == 5'd0));
                    fmt        = ImmI;
                end
            end
            default: bad = 1'b1;
        endcase
        if (inst[1:0] != 2'b11) begin
            bad = 1'b1;
        end
        if (bad) begin
            fmt = ImmNone;
        end
    end

    assign ctrl    = bad ? fields : dec;
    assign imm     = imm_extract(inst, fmt);
    assign illegal = bad;

endmodule

// File: rtl/rv_dec_mt.sv
// Multithreaded decode stage: input decoder, main+skid pipeline and per-thread redirect stall.
module rv_dec_mt
    import rv_pkg::*;
#(
    parameter int unsigned NTHREADS = 4,
    parameter int unsigned TID_W    = (NTHREADS > 1) ? $clog2(NTHREADS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [31:0]      in_pc,
    input  logic [TID_W-1:0] in_tid,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [31:0]      out_pc,
    output logic [TID_W-1:0] out_tid,
    output dec_ctrl_t        out_ctrl,
    output logic [31:0]      out_imm,
    output logic             out_illegal,

    input  logic             redirect_valid,
    input  logic [TID_W-1:0] redirect_tid,
    input  logic             flush_valid,
    input  logic [TID_W-1:0] flush_tid
);

    typedef struct packed {
        logic [31:0]      inst;
        logic [31:0]      pc;
        logic [TID_W-1:0] tid;
        dec_ctrl_t        ctrl;
        logic [31:0]      imm;
        logic             illegal;
    } entry_t;

    entry_t              main_q, main_d;
    entry_t              skid_q, skid_d;
    entry_t              in_entry;
    logic                main_v_q, main_v_d;
    logic                skid_v_q, skid_v_d;
    logic [NTHREADS-1:0] pend_q, pend_d;

    dec_ctrl_t           in_ctrl;
    logic [31:0]         in_imm;
    logic                in_illegal;

    logic [TID_W-1:0]    tid_eff, flush_tid_eff, redirect_tid_eff;
    logic                pend_sel;
    logic                main_kill, skid_kill, in_kill;
    logic                accept, in_live, drain, main_keep, skid_live;

    rv_dec_core u_core (
        .inst    (in_inst),
        .ctrl    (in_ctrl),
        .imm     (in_imm),
        .illegal (in_illegal)
    );

    // A single-thread build ignores all thread ids.
    assign tid_eff          = (NTHREADS == 1) ? '0 : in_tid;
    assign flush_tid_eff    = (NTHREADS == 1) ? '0 : flush_tid;
    assign redirect_tid_eff = (NTHREADS == 1) ? '0 : redirect_tid;

    always_comb begin
        in_entry.inst    = in_inst;
        in_entry.pc      = in_pc;
        in_entry.tid     = tid_eff;
        in_entry.ctrl    = in_ctrl;
        in_entry.imm     = in_imm;
        in_entry.illegal = in_illegal;
    end

    always_comb begin
        pend_sel = 1'b0;
        for (int t = 0; t < NTHREADS; t++) begin
            if (tid_eff == t[TID_W-1:0]) begin
                pend_sel = pend_q[t];
            end
        end
    end

    assign in_ready  = !skid_v_q && !pend_sel;
    assign main_kill = flush_valid && (main_q.tid == flush_tid_eff);
    assign skid_kill = flush_valid && (skid_q.tid == flush_tid_eff);
    assign in_kill   = flush_valid && (tid_eff == flush_tid_eff);

    assign out_valid = main_v_q && !main_kill;
    assign accept    = in_valid && in_ready;
    assign in_live   = accept && !in_kill;
    assign drain     = out_valid && out_ready;
    assign main_keep = out_valid && !out_ready;
    assign skid_live = skid_v_q && !skid_kill;

    // Surviving entries compact oldest-first into main, then skid. An input is only
    // accepted with skid empty, so at most two survivors exist.
    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = 1'b0;
        skid_v_d = 1'b0;
        if (main_keep) begin
            main_v_d = 1'b1;
            if (skid_live) begin
                skid_v_d = 1'b1;
            end else if (in_live) begin
                skid_d   = in_entry;
                skid_v_d = 1'b1;
            end
        end else if (skid_live) begin
            main_d   = skid_q;
            main_v_d = 1'b1;
        end else if (in_live) begin
            main_d   = in_entry;
            main_v_d = 1'b1;
        end
    end

    // A discarded (flushed) input never stalls its thread; otherwise set beats clear.
    always_comb begin
        pend_d = pend_q;
        for (int t = 0; t < NTHREADS; t++) begin
            if ((redirect_valid && (redirect_tid_eff == t[TID_W-1:0])) ||
                (flush_valid && (flush_tid_eff == t[TID_W-1:0]))) begin
                pend_d[t] = 1'b0;
            end
            if (in_live && (tid_eff == t[TID_W-1:0]) && (in_ctrl.pc_load || in_illegal)) begin
                pend_d[t] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            pend_q   <= '0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            pend_q   <= pend_d;
        end
    end

    assign out_inst    = main_q.inst;
    assign out_pc      = main_q.pc;
    assign out_tid     = main_q.tid;
    assign out_ctrl    = main_q.ctrl;
    assign out_imm     = main_q.imm;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_rv_dec_mt.sv
// Bench for rv_dec_mt: directed scenarios plus random traffic against an in-order queue model.
module tb_rv_dec_mt;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_inst, in_pc;
    logic [1:0]  in_tid;
    logic        out_valid, out_ready;
    logic [31:0] out_inst, out_pc;
    logic [1:0]  out_tid;
    dec_ctrl_t   out_ctrl;
    logic [31:0] out_imm;
    logic        out_illegal;
    logic        redirect_valid, flush_valid;
    logic [1:0]  redirect_tid, flush_tid;

    always #5 clk = ~clk;

    rv_dec_mt #(
        .NTHREADS (4),
        .TID_W    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_inst        (in_inst),
        .in_pc          (in_pc),
        .in_tid         (in_tid),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_tid        (out_tid),
        .out_ctrl       (out_ctrl),
        .out_imm        (out_imm),
        .out_illegal    (out_illegal),
        .redirect_valid (redirect_valid),
        .redirect_tid   (redirect_tid),
        .flush_valid    (flush_valid),
        .flush_tid      (flush_tid)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference decode. Enable mask order: rs1 rs2 rd f3 f7 mem mem_wr csr csr_wr pc_load.
    function automatic void ref_dec(input logic [31:0] w, output dec_ctrl_t c,
                                    output logic [31:0] imm, output logic ill);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [9:0] m;
        int         fmt;
        op  = w[6:0];
        f3  = w[14:12];
        f7  = w[31:25];
        m   = '0;
        fmt = 0;
        ill = 1'b0;
        case (op)
            7'h03: begin m = 10'b1011010000; fmt = 1; end
            7'h23: begin m = 10'b1101011000; fmt = 2; end
            7'h13: begin
                m   = (f3 == 3'd1 || f3 == 3'd5) ? 10'b1011100000 : 10'b1011000000;
                fmt = 1;
                ill = (f3 == 3'd1 && f7 != 7'h00) ||
                      (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
            end
            7'h33: begin
                m   = 10'b1111100000;
                ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            7'h63: begin m = 10'b1101000001; fmt = 3; end
            7'h6f: begin m = 10'b0010000001; fmt = 5; end
            7'h67: begin m = 10'b1010000001; fmt = 1; end
            7'h37, 7'h17: begin m = 10'b0010000000; fmt = 4; end
            7'h0f: begin m = 10'b0001000000; fmt = 1; end
            7'h73: begin
                if (f3 == 3'd0) begin
                    m = 10'b0000000001;
                end else begin
                    m      = 10'b0010000100;
                    m[9]   = !f3[2];
                    m[1]   = !(f3[1] && w[19:15] == 5'd0);
                    fmt    = 1;
                end
            end
            default: ill = 1'b1;
        endcase
        if (w[1:0] != 2'b11) ill = 1'b1;
        if (ill) begin
            m   = '0;
            fmt = 0;
        end
        case (fmt)
            1: imm = $unsigned($signed(w) >>> 20);
            2: imm = ($unsigned($signed(w) >>> 20) & ~32'h1f) | {27'd0, w[11:7]};
            3: imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
            4: imm = w & 32'hffff_f000;
            5: imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
        c = {op, w[19:15], w[24:20], w[11:7], f3, f7, m};
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [1:0]  tid;
    } ent_t;

    ent_t       q[$];
    logic [3:0] pend_m;

    logic        s_ir, s_ov, s_ill;
    logic [1:0]  s_tid;
    logic [31:0] s_pc, s_imm;
    dec_ctrl_t   s_ctrl;

    // One clock: drive at negedge, check at negedge+1, advance the model at posedge.
    task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic [1:0] tid, input logic ordy, input logic rv,
                        input logic [1:0] rtid, input logic fv, input logic [1:0] ftid,
                        input logic rst);
        bit          exp_ir, exp_ov, acc, drain;
        dec_ctrl_t   c;
        logic [31:0] im;
        logic        il;
        ent_t        e;
        rst_n = rst; in_valid = v; in_inst = inst; in_pc = pc; in_tid = tid;
        out_ready = ordy; redirect_valid = rv; redirect_tid = rtid;
        flush_valid = fv; flush_tid = ftid;
        #1;
        exp_ir = (q.size() < 2) && !pend_m[tid];
        exp_ov = (q.size() > 0) && !(fv && q[0].tid == ftid);
        check_val("in_ready", in_ready, exp_ir);
        check_val("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            ref_dec(q[0].inst, c, im, il);
            check_val("out_inst", out_inst, q[0].inst);
            check_val("out_pc", out_pc, q[0].pc);
            check_val("out_tid", out_tid, q[0].tid);
            check_val("out_ctrl", out_ctrl, c);
            check_val("out_imm", out_imm, im);
            check_val("out_illegal", out_illegal, il);
        end
        s_ir = in_ready; s_ov = out_valid; s_tid = out_tid; s_pc = out_pc;
        s_ctrl = out_ctrl; s_imm = out_imm; s_ill = out_illegal;
        acc   = v && exp_ir;
        drain = exp_ov && ordy;
        @(posedge clk);
        if (!rst) begin
            q.delete();
            pend_m = '0;
        end else begin
            if (drain) void'(q.pop_front());
            if (fv) begin
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (q[i].tid == ftid) q.delete(i);
                end
            end
            if (rv) pend_m[rtid] = 1'b0;
            if (fv) pend_m[ftid] = 1'b0;
            if (acc && !(fv && tid == ftid)) begin
                e.inst = inst; e.pc = pc; e.tid = tid;
                q.push_back(e);
                ref_dec(inst, c, im, il);
                if (c.pc_load || il) pend_m[tid] = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [1:0] tid, input logic ordy);
        step(1'b0, 32'd0, 32'd0, tid, ordy, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops[11];
        logic [31:0] w;
        int          r;
        ops = '{7'h03, 7'h0f, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6f, 7'h73};
        w = $urandom;
        r = $urandom_range(0, 14);
        if (r < 11) begin
            w[6:0] = ops[r];
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                default: ;
            endcase
            if (ops[r] == 7'h73 && $urandom_range(0, 2) == 0) w[14:12] = 3'd0;
            if ($urandom_range(0, 3) == 0) w[19:15] = 5'd0;
        end
        return w;
    endfunction

    initial begin
        pend_m = '0;
        rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; in_tid = '0;
        out_ready = 1'b0; redirect_valid = 1'b0; redirect_tid = '0;
        flush_valid = 1'b0; flush_tid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        idle(2'd0, 1'b1);
        check_val("rst_in_ready", s_ir, 1'b1);
        check_val("rst_out_ctrl", out_ctrl, 64'd0);
        check_val("rst_out_imm", out_imm, 32'd0);
        check_val("rst_out_inst", out_inst, 32'd0);
        check_val("rst_out_pc", out_pc, 32'd0);
        check_val("rst_out_tid", out_tid, 2'd0);
        check_val("rst_out_illegal", out_illegal, 1'b0);

        // ADD x3,x1,x2
        step(1'b1, 32'h002081B3, 32'h100, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        idle(2'd0, 1'b1);
        check_val("add_valid", s_ov, 1'b1);
        check_val("add_rd", s_ctrl.rd, 5'd3);
        check_val("add_en", {s_ctrl.rs1_en, s_ctrl.rs2_en, s_ctrl.rd_wr}, 3'b111);
        check_val("add_imm", s_imm, 32'd0);

        // Back-pressure over three offers
        step(1'b1, 32'h00208233, 32'h200, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        step(1'b1, 32'h002082B3, 32'h204, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        step(1'b1, 32'h002081B3, 32'h208, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        check_val("bp_third_ready", s_ir, 1'b0);
        idle(2'd0, 1'b1);
        check_val("bp_first_pc", s_pc, 32'h200);
        idle(2'd0, 1'b1);
        check_val("bp_second_pc", s_pc, 32'h204);
        idle(2'd0, 1'b1);
        check_val("bp_empty", s_ov, 1'b0);

        // JAL stalls its own thread until redirect
        step(1'b1, 32'h0000006F, 32'h300, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        idle(2'd1, 1'b1);
        check_val("pend_t1", s_ir, 1'b0);
        idle(2'd2, 1'b1);
        check_val("pend_t2_free", s_ir, 1'b1);
        step(1'b0, 32'd0, 32'd0, 2'd1, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 1'b1);
        idle(2'd1, 1'b1);
        check_val("redirect_t1", s_ir, 1'b1);

        // Illegal encodings
        step(1'b1, 32'hFFFFFFFF, 32'h400, 2'd2, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        step(1'b1, 32'h022081B3, 32'h404, 2'd3, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        check_val("ill_ffff", s_ill, 1'b1);
        check_val("ill_ffff_en", s_ctrl[9:0], 10'd0);
        idle(2'd2, 1'b1);
        check_val("ill_mul", s_ill, 1'b1);
        check_val("ill_mul_en", s_ctrl[9:0], 10'd0);
        check_val("ill_pend_t2", s_ir, 1'b0);
        idle(2'd3, 1'b1);
        check_val("ill_pend_t3", s_ir, 1'b0);
        step(1'b0, 32'd0, 32'd0, 2'd0, 1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 1'b1);
        step(1'b0, 32'd0, 32'd0, 2'd0, 1'b1, 1'b1, 2'd3, 1'b0, 2'd0, 1'b1);

        // Flush of the thread held in main while skid holds another thread
        step(1'b1, 32'h002081B3, 32'h500, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        step(1'b1, 32'h00208233, 32'h504, 2'd3, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        step(1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b1);
        check_val("flush_kill_main", s_ov, 1'b0);
        idle(2'd0, 1'b1);
        check_val("flush_next_valid", s_ov, 1'b1);
        check_val("flush_next_tid", s_tid, 2'd3);
        idle(2'd0, 1'b1);

        // Reset with both registers full and a pending thread
        step(1'b1, 32'h0000006F, 32'h600, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        step(1'b1, 32'h002081B3, 32'h604, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        step(1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        idle(2'd0, 1'b1);
        check_val("rst_mid_valid", s_ov, 1'b0);
        check_val("rst_mid_pend", s_ir, 1'b1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 9) < 7), rand_inst(), $urandom, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 199) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
